// File: rtl/abc_pkg.sv
// Shared constants and types for the line-oriented character counter.
package abc_pkg;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        CONV,
        EMIT
    } state_t;

    // 10^n as a constant, used to prove the BCD field can hold the saturated count.
    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/abc_bin2bcd.sv
// Iterative double-dabble: one shift per cycle, CNT_W cycles per conversion.
// DONE is asserted during the cycle whose edge performs the final shift, so
// BCD holds the finished result from the following cycle onward.
module abc_bin2bcd #(
    parameter int CNT_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic                  START,
    input  logic [CNT_W-1:0]      BIN,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int SC_W = $clog2(CNT_W + 1);

    logic [CNT_W-1:0]    shift_q;
    logic [SC_W-1:0]     shift_cnt;
    logic                busy;
    logic [4*DIGITS-1:0] bcd_adj;

    // Add 3 to every digit that is 5 or more before the next left shift.
    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] b);
        logic [4*DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = add3(BCD);
    assign DONE    = busy && (shift_cnt == SC_W'(1));

    // Conversion control: load the shift count on START, count down while busy.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            busy      <= 1'b0;
            shift_cnt <= '0;
        end else if (START) begin
            busy      <= 1'b1;
            shift_cnt <= SC_W'(CNT_W);
        end else if (busy) begin
            busy      <= (shift_cnt != SC_W'(1));
            shift_cnt <= shift_cnt - SC_W'(1);
        end
    end

    // Conversion datapath: binary shifts out MSB first into the adjusted BCD field.
    always_ff @(posedge CLK) begin
        if (START) begin
            shift_q <= BIN;
            BCD     <= '0;
        end else if (busy) begin
            shift_q <= shift_q << 1;
            BCD     <= {bcd_adj[4*DIGITS-2:0], shift_q[CNT_W-1]};
        end
    end

endmodule

// File: rtl/abc_char_count.sv
// Counts TARGET_CHAR bytes in each LF-terminated input line and emits the
// count as a decimal ASCII string followed by LF.
module abc_char_count
    import abc_pkg::*;
#(
    parameter logic [7:0] TARGET_CHAR = 8'h31,
    parameter int         CNT_W       = 8,
    parameter int         DIGITS      = 3
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       SINK_VALID,
    input  logic [7:0] SINK_DATA,
    output logic       SINK_READY,
    output logic       SOURCE_VALID,
    output logic [7:0] SOURCE_DATA
);

    localparam int     IDX_W   = $clog2(DIGITS + 1);
    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    // LF terminates a line, so it can never also be the counted character,
    // and the BCD field must be wide enough for the saturated count.
    if (TARGET_CHAR == ASCII_LF) begin : g_bad_target
        $error("abc_char_count: TARGET_CHAR must not be LF");
    end
    if (pow10(DIGITS) <= MAX_CNT) begin : g_bad_digits
        $error("abc_char_count: DIGITS too small for CNT_W");
    end

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                conv_start;
    logic                conv_done;
    logic [4*DIGITS-1:0] bcd;
    logic [IDX_W-1:0]    dig_idx;
    logic [IDX_W-1:0]    msd;
    logic                lz_flag;
    logic                lf_phase;
    logic                emit_valid;
    logic [7:0]          emit_byte;

    // Index of the most significant non-zero digit; 0 when the value is zero
    // so the units digit is always printed.
    function automatic logic [IDX_W-1:0] find_msd(input logic [4*DIGITS-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] != 4'd0) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] b,
                                            input logic [IDX_W-1:0]    i);
        return b[4*i +: 4];
    endfunction

    assign accept = SINK_VALID && (state == COUNT);
    assign msd    = find_msd(bcd);

    abc_bin2bcd #(
        .CNT_W  (CNT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .START   (conv_start),
        .BIN     (cnt),
        .DONE    (conv_done),
        .BCD     (bcd)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: count a line, convert, emit, then back to counting.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = COUNT;
            COUNT: if (accept && (SINK_DATA == ASCII_LF)) state_nxt = CONV;
            CONV:  if (conv_done) state_nxt = EMIT;
            EMIT:  if (lf_phase) state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: ready only while counting, converter kick on LF, byte to emit.
    always_comb begin
        SINK_READY = (state == COUNT);
        conv_start = accept && (SINK_DATA == ASCII_LF);
        emit_valid = 1'b0;
        emit_byte  = ASCII_LF;
        if (state == EMIT) begin
            emit_valid = 1'b1;
            if (lf_phase) begin
                emit_byte = ASCII_LF;
            end else if (lz_flag) begin
                emit_byte = ASCII_ZERO + {4'd0, digit_at(bcd, msd)};
            end else begin
                emit_byte = ASCII_ZERO + {4'd0, digit_at(bcd, dig_idx)};
            end
        end
    end

    // Saturating target counter; the LF that closes a line hands cnt to the converter and clears it.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            cnt <= '0;
        end else if (accept) begin
            if (SINK_DATA == TARGET_CHAR) begin
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (SINK_DATA == ASCII_LF) begin
                cnt <= '0;
            end
        end
    end

    // Digit walk: the first EMIT cycle jumps straight to the most significant
    // digit, then steps down to the units digit, then one LF cycle.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            lz_flag  <= 1'b1;
            lf_phase <= 1'b0;
            dig_idx  <= '0;
        end else if ((state == CONV) && conv_done) begin
            lz_flag  <= 1'b1;
            lf_phase <= 1'b0;
        end else if ((state == EMIT) && !lf_phase) begin
            if (lz_flag) begin
                lz_flag <= 1'b0;
                if (msd == '0) begin
                    lf_phase <= 1'b1;
                end else begin
                    dig_idx <= msd - IDX_W'(1);
                end
            end else if (dig_idx == '0) begin
                lf_phase <= 1'b1;
            end else begin
                dig_idx <= dig_idx - IDX_W'(1);
            end
        end
    end

    // Output register: strobe per byte, data holds between strobes.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            SOURCE_VALID <= 1'b0;
            SOURCE_DATA  <= 8'h00;
        end else begin
            SOURCE_VALID <= emit_valid;
            if (emit_valid) begin
                SOURCE_DATA <= emit_byte;
            end
        end
    end

endmodule

// File: tb/tb_abc_char_count.sv
// Bench for abc_char_count: drives ASCII lines, compares the emitted decimal
// strings and their timing against a string-level reference model.
module tb_abc_char_count;

    localparam int CNT_W = 8;
    localparam int LAT   = CNT_W + 1;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, r1, ov0, ov1;
    logic [7:0] od0, od1;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int sel = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         c0[$];
    int         c1[$];

    abc_char_count dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .SINK_VALID(v0), .SINK_DATA(d0), .SINK_READY(r0),
        .SOURCE_VALID(ov0), .SOURCE_DATA(od0)
    );

    abc_char_count #(.TARGET_CHAR(8'h23), .CNT_W(CNT_W), .DIGITS(3)) dut_h (
        .CLK(CLK), .RESET_n(RESET_n),
        .SINK_VALID(v1), .SINK_DATA(d1), .SINK_READY(r1),
        .SOURCE_VALID(ov1), .SOURCE_DATA(od1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Record every emitted byte with the number of the edge that registered it.
    always @(negedge CLK) begin
        if (ov0) begin q0.push_back(od0); c0.push_back(cyc); end
        if (ov1) begin q1.push_back(od1); c1.push_back(cyc); end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, want finish");
        $fatal(1);
    end

    // Reference: count target bytes before LF, saturate, print in decimal.
    function automatic string model(input string line, input logic [7:0] tgt);
        int n;
        n = 0;
        for (int i = 0; i < line.len(); i++) begin
            if (line[i] == 8'h0A) break;
            if (line[i] == tgt) n++;
        end
        if (n > SAT) n = SAT;
        return $sformatf("%0d\n", n);
    endfunction

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else if (s[i] == 8'h0D) r = {r, "\\r"};
            else r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        if (sel == 0) begin v0 = v; d0 = b; end
        else begin v1 = v; d1 = b; end
    endtask

    function automatic logic rdy();
        return (sel == 0) ? r0 : r1;
    endfunction

    function automatic bit has_lf();
        if (sel == 0) begin
            foreach (q0[i]) if (q0[i] == 8'h0A) return 1'b1;
        end else begin
            foreach (q1[i]) if (q1[i] == 8'h0A) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Hold the byte until accepted; acc is the accepting edge number.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        drive(1'b1, b);
        while (!rdy() && n < 200) begin step(); n++; end
        if (n >= 200) begin
            n_total++;
            $display("FAIL send_timeout ready=0 want ready=1");
        end
        step();
        acc = cyc;
        drive(1'b0, b);
    endtask

    task automatic send_line(input string s, input int gap, output int e0);
        int acc;
        acc = 0;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], acc);
            if (gap > 0 && i < s.len() - 1) repeat ($urandom_range(gap, 0)) step();
        end
        e0 = acc;
    endtask

    // Gather one output line (up to LF) with its first edge and contiguity.
    task automatic collect(output string s, output int first, output bit contig);
        int n, c, prev;
        logic [7:0] b;
        bit got_lf;
        s = ""; first = -1; contig = 1'b1; prev = 0; got_lf = 1'b0; n = 0;
        while (!has_lf() && n < 100) begin step(); n++; end
        if (!has_lf()) begin s = "<timeout>"; return; end
        while (!got_lf) begin
            if (sel == 0) begin b = q0.pop_front(); c = c0.pop_front(); end
            else begin b = q1.pop_front(); c = c1.pop_front(); end
            if (first < 0) first = c;
            else if (c != prev + 1) contig = 1'b0;
            prev = c;
            s = $sformatf("%s%c", s, b);
            if (b == 8'h0A) got_lf = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        repeat (3) step();
        n_total++;
        if (ov0 !== 1'b0) $display("FAIL reset_valid got=%b want=0", ov0); else n_pass++;
        n_total++;
        if (od0 !== 8'h00) $display("FAIL reset_data got=%h want=00", od0); else n_pass++;
        RESET_n = 1'b1;
        n_total++;
        if (r0 !== 1'b0) $display("FAIL reset_ready_idle got=%b want=0", r0); else n_pass++;
        step();
        n_total++;
        if (r0 !== 1'b1) $display("FAIL reset_ready_count got=%b want=1", r0); else n_pass++;
    endtask

    task automatic test_basic();
        int e0, first;
        string s;
        bit contig, rd_ok;
        sel = 0;
        send_line("101\n", 0, e0);
        rd_ok = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (r0 !== ((k == LAT + 1) ? 1'b1 : 1'b0)) rd_ok = 1'b0;
            step();
        end
        n_total++;
        if (!rd_ok) $display("FAIL basic_ready_window got=bad want=low until LF out"); else n_pass++;
        collect(s, first, contig);
        n_total++;
        if (s != "2\n") $display("FAIL basic_out got=%s want=2\\n", vis(s)); else n_pass++;
        n_total++;
        if (first != e0 + LAT) $display("FAIL basic_latency got=%0d want=%0d", first - e0, LAT); else n_pass++;
        n_total++;
        if (!contig) $display("FAIL basic_contig got=gap want=consecutive"); else n_pass++;
        n_total++;
        if (ov0 !== 1'b0 || od0 !== 8'h0A)
            $display("FAIL basic_hold got=%b/%h want=0/0a", ov0, od0);
        else n_pass++;
    endtask

    task automatic test_zero_lines();
        string lines[3];
        int gaps[3];
        int e0, first;
        string s;
        bit contig;
        lines = '{"000\r\n", "\n", "111\n"};
        gaps  = '{0, 0, 4};
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            send_line(lines[i], gaps[i], e0);
            collect(s, first, contig);
            n_total++;
            if (s != model(lines[i], 8'h31))
                $display("FAIL zero_out%0d got=%s want=%s", i, vis(s), vis(model(lines[i], 8'h31)));
            else n_pass++;
            n_total++;
            if (first != e0 + LAT) $display("FAIL zero_latency%0d got=%0d want=%0d", i, first - e0, LAT); else n_pass++;
        end
    endtask

    task automatic test_hash();
        string line, s;
        int nh, nd, e0, first;
        bit contig;
        line = ""; nh = 130; nd = 20;
        while (nh + nd > 0) begin
            if (nd == 0 || (nh > 0 && $urandom_range(149, 0) >= 20)) begin
                line = {line, "#"}; nh--;
            end else begin
                line = {line, "."}; nd--;
            end
        end
        line = {line, "\r\n"};
        sel = 1;
        send_line(line, 0, e0);
        collect(s, first, contig);
        n_total++;
        if (s != "130\n") $display("FAIL hash_out got=%s want=130\\n", vis(s)); else n_pass++;
        n_total++;
        if (first != e0 + LAT) $display("FAIL hash_latency got=%0d want=%0d", first - e0, LAT); else n_pass++;
        n_total++;
        if (!contig) $display("FAIL hash_contig got=gap want=consecutive"); else n_pass++;
        sel = 0;
    endtask

    task automatic test_saturation();
        string line, s;
        int e0, first;
        bit contig;
        line = "";
        for (int i = 0; i < 300; i++) line = {line, "1"};
        line = {line, "\n"};
        sel = 0;
        send_line(line, 0, e0);
        collect(s, first, contig);
        n_total++;
        if (s != model(line, 8'h31)) $display("FAIL sat_out got=%s want=%s", vis(s), vis(model(line, 8'h31))); else n_pass++;
        n_total++;
        if (!contig || first != e0 + LAT) $display("FAIL sat_timing got=%0d want=%0d", first - e0, LAT); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e0a, e0b, acc, first;
        string s;
        bit contig;
        sel = 0;
        send_line("1\n", 0, e0a);
        send_byte(8'h31, acc);
        send_byte(8'h0A, e0b);
        n_total++;
        if (acc != e0a + LAT + 2) $display("FAIL bp_accept_edge got=%0d want=%0d", acc - e0a, LAT + 2); else n_pass++;
        collect(s, first, contig);
        n_total++;
        if (s != "1\n") $display("FAIL bp_out1 got=%s want=1\\n", vis(s)); else n_pass++;
        n_total++;
        if (first != e0a + LAT) $display("FAIL bp_latency1 got=%0d want=%0d", first - e0a, LAT); else n_pass++;
        collect(s, first, contig);
        n_total++;
        if (s != "1\n") $display("FAIL bp_out2 got=%s want=1\\n", vis(s)); else n_pass++;
        n_total++;
        if (first != e0b + LAT) $display("FAIL bp_latency2 got=%0d want=%0d", first - e0b, LAT); else n_pass++;
    endtask

    task automatic test_random();
        string cs, line, s, want;
        int len, e0, first;
        bit contig;
        cs = "10 \r1a#";
        sel = 0;
        for (int t = 0; t < 6; t++) begin
            line = "";
            len = $urandom_range(20, 0);
            for (int i = 0; i < len; i++)
                line = $sformatf("%s%c", line, cs[$urandom_range(cs.len() - 1, 0)]);
            line = {line, "\n"};
            want = model(line, 8'h31);
            send_line(line, 2, e0);
            collect(s, first, contig);
            n_total++;
            if (s != want) $display("FAIL rand_out%0d got=%s want=%s", t, vis(s), vis(want)); else n_pass++;
            n_total++;
            if (!contig || first != e0 + LAT) $display("FAIL rand_timing%0d got=%0d want=%0d", t, first - e0, LAT); else n_pass++;
        end
    endtask

    task automatic test_reset_emit();
        int e0, first, n;
        string s;
        bit contig;
        sel = 0;
        q0.delete(); c0.delete();
        send_line("111111111111\n", 0, e0);
        n = 0;
        while (cyc < e0 + LAT + 1 && n < 50) begin step(); n++; end
        n_total++;
        if (q0.size() != 2 || q0[0] !== 8'h31 || q0[1] !== 8'h32)
            $display("FAIL rst_emit_prefix got=%0d bytes want=2 bytes 31,32", q0.size());
        else n_pass++;
        RESET_n = 1'b0;
        step();
        RESET_n = 1'b1;
        n_total++;
        if (ov0 !== 1'b0 || od0 !== 8'h00) $display("FAIL rst_emit_out got=%b/%h want=0/00", ov0, od0); else n_pass++;
        n_total++;
        if (r0 !== 1'b0) $display("FAIL rst_emit_ready got=%b want=0", r0); else n_pass++;
        repeat (3) step();
        n_total++;
        if (q0.size() != 2) $display("FAIL rst_emit_no_lf got=%0d bytes want=2", q0.size()); else n_pass++;
        q0.delete(); c0.delete();
        send_line("11\n", 0, e0);
        collect(s, first, contig);
        n_total++;
        if (s != "2\n") $display("FAIL rst_restart_out got=%s want=2\\n", vis(s)); else n_pass++;
        n_total++;
        if (first != e0 + LAT) $display("FAIL rst_restart_latency got=%0d want=%0d", first - e0, LAT); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_lines();
        test_hash();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_emit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
